parity_tx_sched: RTL

- Round-robin scheduler that shares one even-parity generator and one serial line between NUM_REQ requesters.
- Each granted word is captured, its parity bit is generated as the XOR of all data bits, and a frame is serialized: start, data LSB first, parity, stop.
- It also runs an on-the-fly parity self-check: the XOR of the data bits and the parity bit must be 0.
- Sits between the word-level producers and the serial link of the parity drill datapath.

---
 rtl/parity_tx_sched_pkg.sv | 16 +
 rtl/parity_tx_sched_if.sv | 22 ++
 rtl/parity_tx_sched_rr_arbiter.sv | 32 +++
 rtl/parity_tx_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/parity_tx_sched_pkg.sv
// parity_tx_sched shared definitions.
// State encoding and serial line levels.
package parity_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/parity_tx_sched_if.sv
// Requester-side word handshake bundle.
// One valid/ready pair and one data slice per requester.
interface parity_tx_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/parity_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Search begins just after the last grant and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    // First valid requester after the pointer wins.
    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(ptr_i) + k) % NUM_REQ;
            if (en_i && !any_o && valid_i[c]) begin
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_tx_sched.sv
// Round-robin scheduler feeding one even-parity serial framer.
// Frame: start, data LSB first, parity, stop; with parity self-check.
module parity_tx_sched
    import parity_tx_sched_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter int NUM_REQ    = 2,
    parameter int BIT_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    parity_tx_sched_if.slave           req,
    output logic                       tx_out,
    output logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done,
    output logic                       chk_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [3:0] CYC_LAST = 4'(BIT_CYCLES - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

    state_e state_q, state_d;
    logic [3:0] cyc_q, cyc_d;
    logic [2:0] bitc_q, bitc_d;
    logic [DATA_W-1:0] sh_q, sh_d, sh_nx, word;
    logic par_q, par_d;
    logic acc_q, acc_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [IW-1:0] win_idx;
    logic tx_q, tx_d;
    logic busy_q, busy_d;
    logic fd_q, fd_d;
    logic err_q, err_d;
    logic [NUM_REQ-1:0] gnt;
    logic win_any;
    logic arb_en;
    logic wrap;

    // Ready is held low during reset even if valids are high.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IW     (IW)
    ) u_arb (
        .valid_i(req.req_valid),
        .ptr_i  (ptr_q),
        .en_i   (arb_en),
        .gnt_o  (gnt),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    assign req.req_ready = gnt;
    assign word  = req.req_data[win_idx*DATA_W +: DATA_W];
    assign wrap  = (cyc_q == CYC_LAST);
    assign sh_nx = sh_q >> 1;

    assign tx_out     = tx_q;
    assign tx_busy    = busy_q;
    assign grant_id   = gid_q;
    assign frame_done = fd_q;
    assign chk_err    = err_q;

    // Next state plus next value of every registered output.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bitc_d  = bitc_q;
        sh_d    = sh_q;
        par_d   = par_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        tx_d    = tx_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (win_any) begin
                    sh_d    = word;
                    par_d   = ^word;
                    gid_d   = win_idx;
                    ptr_d   = win_idx;
                    cyc_d   = '0;
                    bitc_d  = '0;
                    acc_d   = 1'b0;
                    tx_d    = START_BIT;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (wrap) begin
                    cyc_d   = '0;
                    tx_d    = sh_q[0];
                    state_d = ST_DATA;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_DATA: begin
                if (wrap) begin
                    cyc_d = '0;
                    acc_d = acc_q ^ sh_q[0];
                    sh_d  = sh_nx;
                    if (bitc_q == BIT_LAST) begin
                        bitc_d  = '0;
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        bitc_d = bitc_q + 3'd1;
                        tx_d   = sh_nx[0];
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_PARITY: begin
                if (wrap) begin
                    cyc_d   = '0;
                    err_d   = err_q | (acc_q ^ par_q);
                    tx_d    = LINE_IDLE;
                    state_d = ST_STOP;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_STOP: begin
                if (wrap) begin
                    cyc_d   = '0;
                    tx_d    = LINE_IDLE;
                    state_d = ST_IDLE;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            default: begin
                cyc_d   = '0;
                tx_d    = LINE_IDLE;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        fd_d   = (state_d == ST_STOP) && (cyc_d == CYC_LAST);
    end

    // State and output registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bitc_q  <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            acc_q   <= 1'b0;
            ptr_q   <= IW'(NUM_REQ - 1);
            gid_q   <= '0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bitc_q  <= bitc_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

endmodule
